// File: rtl/entity_table_scheduler_pkg.sv
// Shared entity-slot definitions used by the scheduler, the frame buffer controller and game logic.
package entity_table_scheduler_pkg;

    localparam int ENTITY_W    = 15;
    localparam int NUM_SLOTS   = 15;
    localparam int COMMIT_LINE = 480;
    localparam int SLOT_IDX_W  = 4;
    localparam int VCOUNT_W    = 10;

    // Field offsets inside a slot word
    localparam int FLAG_BIT    = 14;
    localparam int ID_LSB      = 10;
    localparam int ID_W        = 4;
    localparam int ORIENT_LSB  = 8;
    localparam int ORIENT_W    = 2;
    localparam int HTILE_LSB   = 4;
    localparam int VTILE_LSB   = 0;
    localparam int TILE_W      = 4;

    localparam logic [ID_W-1:0] ID_UNUSED = 4'hF;

    typedef logic [ENTITY_W-1:0] entity_t;

    localparam entity_t SLOT_RESET = {1'b0, ID_UNUSED, 10'b0};

    function automatic logic [ID_W-1:0] entity_id(input entity_t e);
        return e[ID_LSB +: ID_W];
    endfunction

endpackage

// File: rtl/entity_table_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanning upward from a registered pointer.
module entity_table_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_REQ-1:0]                           req,
    input  logic                                         hold,
    output logic [NUM_REQ-1:0]                           grant,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] ptr
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr_reg, ptr_next;
    logic [PW:0]   scan_sum;
    logic [PW-1:0] scan_idx;
    logic [PW-1:0] win_idx;
    logic          found;

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        win_idx  = ptr_reg;
        scan_sum = '0;
        scan_idx = ptr_reg;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr and k are both below NUM_REQ, so one subtraction is a full modulo
            scan_sum = {1'b0, ptr_reg} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NUM_REQ))
                scan_sum = scan_sum - (PW+1)'(NUM_REQ);
            scan_idx = scan_sum[PW-1:0];
            if (!found && !hold && req[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                win_idx         = scan_idx;
                found           = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (found)
            ptr_next = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            ptr_reg <= '0;
        else
            ptr_reg <= ptr_next;
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/entity_table_scheduler.sv
// Entity slot table: round-robin writes land in a shadow table, copied to the live table
// once per frame on the first blanking line so the display never tears.
module entity_table_scheduler
    import entity_table_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int NUM_SLOTS   = entity_table_scheduler_pkg::NUM_SLOTS,
    parameter int ENTITY_W    = entity_table_scheduler_pkg::ENTITY_W,
    parameter int COMMIT_LINE = entity_table_scheduler_pkg::COMMIT_LINE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [4*NUM_REQ-1:0]          req_slot,
    input  logic [ENTITY_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [9:0]                    counter_V,
    output logic [ENTITY_W*NUM_SLOTS-1:0] live_table,
    output logic                          commit_pulse,
    output logic                          dirty,
    output logic                          bad_slot
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [9:0]          prev_v_reg;
    logic                commit_now;
    logic                commit_pulse_reg;
    logic                dirty_reg;
    logic                bad_slot_reg;
    logic [NUM_REQ-1:0]  grant;
    logic [PW-1:0]       rr_ptr;
    logic                rr_ptr_unused;
    logic                xfer;
    logic                slot_ok;
    logic [3:0]          sel_slot;
    logic [ENTITY_W-1:0] sel_data;

    // Edge detect so a counter parked on the commit line commits only once
    assign commit_now = (counter_V == 10'(COMMIT_LINE)) && (prev_v_reg != 10'(COMMIT_LINE));

    entity_table_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .hold  (commit_now | ~reset),
        .grant (grant),
        .ptr   (rr_ptr)
    );

    // Pointer is exported by the arbiter for debug visibility only
    assign rr_ptr_unused = ^rr_ptr;

    always_comb begin
        sel_slot = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_slot = req_slot[4*i +: 4];
                sel_data = req_data[ENTITY_W*i +: ENTITY_W];
            end
        end
    end

    assign xfer    = |grant;
    assign slot_ok = ({1'b0, sel_slot} < 5'(NUM_SLOTS));

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic [ENTITY_W-1:0] shadow_reg;
            logic [ENTITY_W-1:0] live_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    shadow_reg <= ENTITY_W'(SLOT_RESET);
                    live_reg   <= ENTITY_W'(SLOT_RESET);
                end else begin
                    if (xfer && (sel_slot == 4'(gi)))
                        shadow_reg <= sel_data;
                    if (commit_now)
                        live_reg <= shadow_reg;
                end
            end

            assign live_table[ENTITY_W*gi +: ENTITY_W] = live_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_v_reg       <= '0;
            commit_pulse_reg <= 1'b0;
            dirty_reg        <= 1'b0;
            bad_slot_reg     <= 1'b0;
        end else begin
            prev_v_reg       <= counter_V;
            commit_pulse_reg <= commit_now;
            // Grant is suppressed during a commit, so these two branches never collide
            if (commit_now)
                dirty_reg <= 1'b0;
            else if (xfer && slot_ok)
                dirty_reg <= 1'b1;
            if (xfer && !slot_ok)
                bad_slot_reg <= 1'b1;
        end
    end

    assign req_ready    = grant;
    assign commit_pulse = commit_pulse_reg;
    assign dirty        = dirty_reg;
    assign bad_slot     = bad_slot_reg;

endmodule

// File: tb/tb_entity_table_scheduler.sv
// Scoreboard bench for entity_table_scheduler: a table-level reference model predicts grants,
// flags and the live table; a negedge monitor compares them and checks every commit pulse.
module tb_entity_table_scheduler;
    import entity_table_scheduler_pkg::*;

    localparam int NR = 4;
    localparam int NS = 15;
    localparam int EW = 15;
    localparam int CL = 480;
    localparam int TW = EW*NS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [4*NR-1:0]  req_slot = '0;
    logic [EW*NR-1:0] req_data = '0;
    logic [9:0]    counter_V = '0;
    logic [NR-1:0] req_ready;
    logic [TW-1:0] live_table;
    logic          commit_pulse;
    logic          dirty;
    logic          bad_slot;

    entity_table_scheduler #(.NUM_REQ(NR)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_slot     (req_slot),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .counter_V    (counter_V),
        .live_table   (live_table),
        .commit_pulse (commit_pulse),
        .dirty        (dirty),
        .bad_slot     (bad_slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] grant;
        logic          dirty;
        logic          bad;
        logic [TW-1:0] live;
    } exp_t;

    exp_t          exp_q[$];
    logic [TW-1:0] commit_q[$];
    int errors = 0;
    int checks = 0;
    int commits_seen = 0;

    // Reference model state: the two tables as plain arrays plus the arbitration pointer
    int          m_ptr;
    logic [EW-1:0] m_shadow[NS];
    logic [EW-1:0] m_live[NS];
    int          m_prev;
    bit          m_dirty;
    bit          m_bad;

    function automatic void model_reset();
        m_ptr = 0; m_prev = 0; m_dirty = 0; m_bad = 0;
        for (int s = 0; s < NS; s++) begin
            m_shadow[s] = 15'h3C00;
            m_live[s]   = 15'h3C00;
        end
    endfunction

    function automatic logic [TW-1:0] pack_live();
        logic [TW-1:0] p;
        p = '0;
        for (int s = 0; s < NS; s++) p[EW*s +: EW] = m_live[s];
        return p;
    endfunction

    function automatic void check(input string name, input logic [TW-1:0] got, input logic [TW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [TW-1:0] lv;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("req_ready", TW'(req_ready), TW'(e.grant));
            check("dirty", TW'(dirty), TW'(e.dirty));
            check("bad_slot", TW'(bad_slot), TW'(e.bad));
            check("live_table", live_table, e.live);
        end
        if (commit_pulse === 1'b1) begin
            if (commit_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit_pulse: got unexpected pulse required none");
            end else begin
                lv = commit_q.pop_front();
                check("commit_live", live_table, lv);
                commits_seen++;
                $display("commit %0d at %0t live_table=%h", commits_seen, $time, live_table);
            end
        end
    end

    task automatic step(input logic [NR-1:0] v, input logic [4*NR-1:0] s,
                        input logic [EW*NR-1:0] d, input int cv, input bit rst_n);
        exp_t e;
        int g;
        int idx;
        logic [3:0] sl;
        @(posedge clk);
        #1;
        reset = rst_n; req_valid = v; req_slot = s; req_data = d; counter_V = cv[9:0];
        e.grant = '0; e.dirty = m_dirty; e.bad = m_bad; e.live = pack_live();
        if (!rst_n) begin
            exp_q.push_back(e);
            model_reset();
            return;
        end
        g = -1;
        if (!(cv == CL && m_prev != CL)) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        if (g >= 0) begin
            e.grant[g] = 1'b1;
            m_ptr = (g + 1) % NR;
            sl = s[4*g +: 4];
            if (sl < NS) begin
                m_shadow[sl] = d[EW*g +: EW];
                m_dirty = 1;
            end else begin
                m_bad = 1;
            end
        end
        exp_q.push_back(e);
        if (cv == CL && m_prev != CL) begin
            for (int k = 0; k < NS; k++) m_live[k] = m_shadow[k];
            m_dirty = 0;
            commit_q.push_back(pack_live());
        end
        m_prev = cv;
    endtask

    task automatic idle(input int cv);
        step('0, '0, '0, cv, 1'b1);
    endtask

    task automatic wr(input int r, input int slot, input logic [EW-1:0] data, input int cv);
        logic [NR-1:0] v;
        logic [4*NR-1:0] s;
        logic [EW*NR-1:0] d;
        v = '0; s = '0; d = '0;
        v[r] = 1'b1;
        s[4*r +: 4] = slot[3:0];
        d[EW*r +: EW] = data;
        step(v, s, d, cv, 1'b1);
    endtask

    initial begin
        int c0;
        int cv;
        int r;
        logic [4*NR-1:0] s;
        logic [EW*NR-1:0] d;
        logic [NR-1:0] v;

        model_reset();
        repeat (2) @(posedge clk);
        step('0, '0, '0, 0, 1'b0);
        repeat (3) idle(0);

        // Single write committed on the first blanking line
        wr(0, 3, 15'h1234, 478);
        idle(479); idle(480); idle(481); idle(482);

        // Park the pointer at 0, then four requesters contend for eight cycles
        wr(3, 0, 15'h0001, 100);
        for (int i = 0; i < 8; i++)
            step(4'hF, {4'd7, 4'd6, 4'd5, 4'd4}, 60'({$urandom(), $urandom()}), 100, 1'b1);

        // Last write to a slot before the commit wins
        wr(1, 5, 15'h0011, 200);
        wr(1, 5, 15'h0022, 201);
        idle(479); idle(480); idle(481);

        // Request pending across the commit cycle is deferred one cycle
        idle(470);
        wr(2, 9, 15'h0ABC, 480);
        wr(2, 9, 15'h0ABC, 481);
        idle(481); idle(479); idle(480); idle(0);

        // Out-of-range slot, then a long stall on the commit line
        wr(0, 15, 15'h7FFF, 200);
        idle(201); idle(479);
        c0 = commits_seen;
        repeat (800) idle(480);
        idle(481); idle(0);
        @(negedge clk); #1;
        check("single_commit_on_hold", TW'(commits_seen - c0), TW'(1));

        cv = 0;
        for (int i = 0; i < 2000; i++) begin
            v = NR'($urandom());
            s = '0; d = '0;
            for (int k = 0; k < NR; k++) begin
                s[4*k +: 4] = 4'($urandom_range(0, 15));
                d[EW*k +: EW] = EW'($urandom());
            end
            r = $urandom_range(0, 9);
            if (r < 4)      cv = 480;
            else if (r < 6) cv = 479;
            else if (r < 7) cv = (cv + 1) % 525;
            else            cv = $urandom_range(0, 524);
            step(v, s, d, cv, (i == 1000 || i == 1001) ? 1'b0 : 1'b1);
        end

        repeat (3) idle(0);
        @(negedge clk); #1;
        check("commit_queue_drained", TW'(commit_q.size()), TW'(0));
        check("expect_queue_drained", TW'(exp_q.size()), TW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
